// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue decoder: RV32I opcodes, ALU operation
// codes, skid-buffer states and the decoded issue bundle.
package alu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_XOR  = 4'b0010, ALU_ADD  = 4'b0011,
    ALU_SUB  = 4'b0100, ALU_SRL  = 4'b0101, ALU_SRA  = 4'b0110, ALU_SLL  = 4'b0111,
    ALU_BEQ  = 4'b1000, ALU_BNE  = 4'b1001, ALU_SLT  = 4'b1010, ALU_BGE  = 4'b1011,
    ALU_JALR = 4'b1100, ALU_LUI  = 4'b1101, ALU_SLTU = 4'b1110, ALU_BGEU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

  typedef struct packed {
    alu_op_e     op;
    logic        is_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } issue_bundle_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Handshake and decoded-bundle signals between the instruction source, the
// issue decoder (slave) and the downstream ALU stage.
interface alu_issue_decoder_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic [31:0]              in_instr;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     isImmediate;
  logic [DATA_WIDTH-1:0]    imm;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [4:0]               rd;
  logic                     reg_write;
  logic                     illegal;
  logic [15:0]              illegal_count;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, Operation, isImmediate, imm, rs1, rs2, rd,
           reg_write, illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, Operation, isImmediate, imm, rs1, rs2, rd,
           reg_write, illegal, illegal_count
  );
endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational RV32I field decode into an ALU issue bundle; anything
// outside the supported subset becomes an illegal bundle.
module instr_field_decode
  import alu_pkg::*;
(
  input  logic [31:0]   instr,
  output issue_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_st, imm_b, imm_u, imm_sh;
  logic        legal_s;
  alu_op_e     op_s;
  logic        is_imm_s;
  logic [31:0] imm_s;
  logic        writes_rd_s;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = sext12(instr[31:20]);
  assign imm_st = sext12({instr[31:25], instr[11:7]});
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  // Opcode/funct classification, then illegal and rd==x0 squashing.
  always_comb begin
    legal_s     = 1'b1;
    op_s        = ALU_AND;
    is_imm_s    = 1'b0;
    imm_s       = 32'd0;
    writes_rd_s = 1'b1;
    case (opcode)
      OPC_LUI: begin
        op_s  = ALU_LUI;
        imm_s = imm_u;
      end
      OPC_JALR: begin
        op_s     = ALU_JALR;
        is_imm_s = 1'b1;
        imm_s    = imm_i;
        legal_s  = (funct3 == 3'b000);
      end
      OPC_LOAD: begin
        op_s     = ALU_ADD;
        is_imm_s = 1'b1;
        imm_s    = imm_i;
        legal_s  = (funct3 == 3'b010);
      end
      OPC_STORE: begin
        op_s        = ALU_ADD;
        is_imm_s    = 1'b1;
        imm_s       = imm_st;
        writes_rd_s = 1'b0;
        legal_s     = (funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        imm_s       = imm_b;
        writes_rd_s = 1'b0;
        case (funct3)
          3'b000:  op_s = ALU_BEQ;
          3'b001:  op_s = ALU_BNE;
          3'b100:  op_s = ALU_SLT;
          3'b101:  op_s = ALU_BGE;
          3'b110:  op_s = ALU_SLTU;
          3'b111:  op_s = ALU_BGEU;
          default: legal_s = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        is_imm_s = 1'b1;
        imm_s    = imm_i;
        case (funct3)
          3'b000: op_s = ALU_ADD;
          3'b010: op_s = ALU_SLT;
          3'b011: op_s = ALU_SLTU;
          3'b100: op_s = ALU_XOR;
          3'b110: op_s = ALU_OR;
          3'b111: op_s = ALU_AND;
          3'b001: begin
            op_s    = ALU_SLL;
            imm_s   = imm_sh;
            legal_s = (funct7 == F7_BASE);
          end
          3'b101: begin
            imm_s = imm_sh;
            if (funct7 == F7_BASE) begin
              op_s = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              op_s = ALU_SRA;
            end else begin
              legal_s = 1'b0;
            end
          end
          default: legal_s = 1'b0;
        endcase
      end
      OPC_OP: begin
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: op_s = ALU_ADD;
          {F7_ALT,  3'b000}: op_s = ALU_SUB;
          {F7_BASE, 3'b001}: op_s = ALU_SLL;
          {F7_BASE, 3'b010}: op_s = ALU_SLT;
          {F7_BASE, 3'b011}: op_s = ALU_SLTU;
          {F7_BASE, 3'b100}: op_s = ALU_XOR;
          {F7_BASE, 3'b101}: op_s = ALU_SRL;
          {F7_ALT,  3'b101}: op_s = ALU_SRA;
          {F7_BASE, 3'b110}: op_s = ALU_OR;
          {F7_BASE, 3'b111}: op_s = ALU_AND;
          default:           legal_s = 1'b0;
        endcase
      end
      default: legal_s = 1'b0;
    endcase

    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
    bundle.rd  = instr[11:7];
    if (legal_s) begin
      bundle.op        = op_s;
      bundle.is_imm    = is_imm_s;
      bundle.imm       = imm_s;
      bundle.reg_write = writes_rd_s && (instr[11:7] != 5'd0);
      bundle.illegal   = 1'b0;
    end else begin
      bundle.op        = ALU_AND;
      bundle.is_imm    = 1'b0;
      bundle.imm       = 32'd0;
      bundle.reg_write = 1'b0;
      bundle.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// RV32I ALU issue decoder: combinational field decode feeding a 2-entry skid
// buffer with valid/ready handshakes and a saturating illegal-bundle counter.
module alu_issue_decoder
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_issue_decoder_if.slave bus
);

  issue_bundle_t dec_s;
  issue_bundle_t head_q, head_d;
  issue_bundle_t tail_q, tail_d;
  buf_state_e    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   illegal_count_q, illegal_count_d;
  logic          out_valid_s, accept_s, deliver_s;

  instr_field_decode u_decode (
    .instr  (bus.in_instr),
    .bundle (dec_s)
  );

  assign out_valid_s = (state_q != BUF_EMPTY);
  assign accept_s    = bus.in_valid && in_ready_q;
  assign deliver_s   = out_valid_s && bus.out_ready;

  // State register: buffer occupancy, entries, ready flag and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= BUF_EMPTY;
      head_q          <= '0;
      tail_q          <= '0;
      in_ready_q      <= 1'b1;
      illegal_count_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      in_ready_q      <= in_ready_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  // Next-state: head is always the oldest entry; tail only fills when head stalls.
  always_comb begin
    state_d         = state_q;
    head_d          = head_q;
    tail_d          = tail_q;
    illegal_count_d = illegal_count_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept_s) begin
          state_d = BUF_ONE;
          head_d  = dec_s;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (accept_s && deliver_s) begin
          head_d = dec_s;
        end else if (accept_s) begin
          state_d = BUF_FULL;
          tail_d  = dec_s;
        end else if (deliver_s) begin
          state_d = BUF_EMPTY;
        end else begin
          state_d = BUF_ONE;
        end
      end
      BUF_FULL: begin
        if (deliver_s) begin
          state_d = BUF_ONE;
          head_d  = tail_q;
        end else begin
          state_d = BUF_FULL;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase

    if (deliver_s && head_q.illegal && (illegal_count_q != 16'hFFFF)) begin
      illegal_count_d = illegal_count_q + 16'd1;
    end else begin
      illegal_count_d = illegal_count_q;
    end
    in_ready_d = (state_d != BUF_FULL);
  end

  // Outputs: everything comes straight from flops.
  always_comb begin
    bus.in_ready      = in_ready_q;
    bus.out_valid     = out_valid_s;
    bus.Operation     = OPCODE_LENGTH'(head_q.op);
    bus.isImmediate   = head_q.is_imm;
    bus.imm           = DATA_WIDTH'($signed(head_q.imm));
    bus.rs1           = head_q.rs1;
    bus.rs2           = head_q.rs2;
    bus.rd            = head_q.rd;
    bus.reg_write     = head_q.reg_write;
    bus.illegal       = head_q.illegal;
    bus.illegal_count = illegal_count_q;
  end

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Self-checking bench: mnemonic-level reference model with a FIFO scoreboard,
// checked every cycle, plus hand-computed expectations on directed vectors.
module tb_alu_issue_decoder;

  typedef struct packed {
    logic [3:0]  op;
    logic        is_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t        mq[$];
  logic [15:0] m_cnt = 16'd0;
  logic        m_fresh = 1'b0;
  logic        m_active = 1'b0;

  alu_issue_decoder_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_issue_decoder #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      if (n_errors <= 50) $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic string mnem(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'h37: return "LUI";
      7'h67: return (f3 == 3'd0) ? "JALR" : "ILL";
      7'h03: return (f3 == 3'd2) ? "LW" : "ILL";
      7'h23: return (f3 == 3'd2) ? "SW" : "ILL";
      7'h63: case (f3)
        3'd0: return "BEQ";  3'd1: return "BNE";  3'd4: return "BLT";
        3'd5: return "BGE";  3'd6: return "BLTU"; 3'd7: return "BGEU";
        default: return "ILL";
      endcase
      7'h13: case (f3)
        3'd0: return "ADDI"; 3'd2: return "SLTI"; 3'd3: return "SLTIU";
        3'd4: return "XORI"; 3'd6: return "ORI";  3'd7: return "ANDI";
        3'd1: return (f7 == 7'h00) ? "SLLI" : "ILL";
        default: return (f7 == 7'h00) ? "SRLI" : (f7 == 7'h20) ? "SRAI" : "ILL";
      endcase
      7'h33: begin
        if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
        if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
        if (f7 != 7'h00) return "ILL";
        case (f3)
          3'd0: return "ADD"; 3'd1: return "SLL"; 3'd2: return "SLT"; 3'd3: return "SLTU";
          3'd4: return "XOR"; 3'd5: return "SRL"; 3'd6: return "OR";  default: return "AND";
        endcase
      end
      default: return "ILL";
    endcase
  endfunction

  function automatic logic [3:0] op_of(input string m);
    case (m)
      "AND", "ANDI":          return 4'b0000;
      "OR", "ORI":            return 4'b0001;
      "XOR", "XORI":          return 4'b0010;
      "ADD", "ADDI", "LW", "SW": return 4'b0011;
      "SUB":                  return 4'b0100;
      "SRL", "SRLI":          return 4'b0101;
      "SRA", "SRAI":          return 4'b0110;
      "SLL", "SLLI":          return 4'b0111;
      "BEQ":                  return 4'b1000;
      "BNE":                  return 4'b1001;
      "SLT", "SLTI", "BLT":   return 4'b1010;
      "BGE":                  return 4'b1011;
      "JALR":                 return 4'b1100;
      "LUI":                  return 4'b1101;
      "SLTU", "SLTIU", "BLTU": return 4'b1110;
      "BGEU":                 return 4'b1111;
      default:                return 4'b0000;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t  e;
    string m;
    m     = mnem(w);
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    if (m == "ILL") begin
      e.op = 4'd0; e.is_imm = 1'b0; e.imm = 32'd0; e.reg_write = 1'b0; e.illegal = 1'b1;
    end else begin
      e.illegal   = 1'b0;
      e.op        = op_of(m);
      e.reg_write = 1'b1;
      if (m == "LUI") begin
        e.imm = {w[31:12], 12'h000}; e.is_imm = 1'b0;
      end else if (w[6:0] == 7'h63) begin
        e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        e.is_imm = 1'b0; e.reg_write = 1'b0;
      end else if (m == "SW") begin
        e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; e.is_imm = 1'b1; e.reg_write = 1'b0;
      end else if (m == "SLLI" || m == "SRLI" || m == "SRAI") begin
        e.imm = {27'd0, w[24:20]}; e.is_imm = 1'b1;
      end else if (w[6:0] == 7'h33) begin
        e.imm = 32'd0; e.is_imm = 1'b0;
      end else begin
        e.imm = {{20{w[31]}}, w[31:20]}; e.is_imm = 1'b1;
      end
      if (w[11:7] == 5'd0) e.reg_write = 1'b0;
    end
    return e;
  endfunction

  // Reference model: FIFO of expected bundles updated on each rising edge.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); m_cnt = 16'd0; m_fresh = 1'b1; m_active = 1'b1;
    end else if (m_active) begin
      logic acc, del;
      acc = bus.in_valid && (mq.size() < 2);
      del = bus.out_ready && (mq.size() > 0);
      if (del) begin
        if (mq[0].illegal && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        void'(mq.pop_front());
        m_fresh = 1'b0;
      end
      if (acc) begin
        mq.push_back(ref_decode(bus.in_instr));
        m_fresh = 1'b0;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_active) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
      chk("illegal_count", {16'd0, bus.illegal_count}, {16'd0, m_cnt});
      if (mq.size() > 0) begin
        chk("Operation", {28'd0, bus.Operation}, {28'd0, mq[0].op});
        chk("isImmediate", {31'd0, bus.isImmediate}, {31'd0, mq[0].is_imm});
        chk("imm", bus.imm, mq[0].imm);
        chk("rs1", {27'd0, bus.rs1}, {27'd0, mq[0].rs1});
        chk("rs2", {27'd0, bus.rs2}, {27'd0, mq[0].rs2});
        chk("rd", {27'd0, bus.rd}, {27'd0, mq[0].rd});
        chk("reg_write", {31'd0, bus.reg_write}, {31'd0, mq[0].reg_write});
        chk("illegal", {31'd0, bus.illegal}, {31'd0, mq[0].illegal});
      end else if (m_fresh) begin
        chk("reset_bundle", {bus.Operation, bus.isImmediate, bus.rs1, bus.rs2, bus.rd,
                             bus.reg_write, bus.illegal, 10'd0}, 32'd0);
        chk("reset_imm", bus.imm, 32'd0);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFB00093;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_BNE  = 32'hFE209EE3;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_XOR  = 32'h0062C233;
  localparam logic [31:0] I_ORI  = 32'h07F46393;
  localparam logic [31:0] I_SRAI = 32'h40355493;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  initial begin
    rst_n = 1'b0;
    cyc(1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_count", {16'd0, bus.illegal_count}, 32'd0);
    rst_n = 1'b1;

    cyc(1'b1, I_ADDI, 1'b1);
    chk("addi_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("addi_op", {28'd0, bus.Operation}, 32'h3);
    chk("addi_isimm", {31'd0, bus.isImmediate}, 32'd1);
    chk("addi_imm", bus.imm, 32'hFFFFFFFB);
    chk("addi_rd", {27'd0, bus.rd}, 32'd1);
    chk("addi_rw", {31'd0, bus.reg_write}, 32'd1);
    cyc(1'b1, I_SUB, 1'b1);
    chk("sub_op", {28'd0, bus.Operation}, 32'h4);
    chk("sub_isimm", {31'd0, bus.isImmediate}, 32'd0);
    chk("sub_rs1", {27'd0, bus.rs1}, 32'd1);
    chk("sub_rs2", {27'd0, bus.rs2}, 32'd2);
    cyc(1'b1, I_ADD, 1'b1);
    chk("add_op", {28'd0, bus.Operation}, 32'h3);
    cyc(1'b1, I_LUI, 1'b1);
    chk("lui_op", {28'd0, bus.Operation}, 32'hD);
    chk("lui_isimm", {31'd0, bus.isImmediate}, 32'd0);
    chk("lui_imm", bus.imm, 32'h12345000);
    cyc(1'b1, I_BNE, 1'b1);
    chk("bne_op", {28'd0, bus.Operation}, 32'h9);
    chk("bne_imm", bus.imm, 32'hFFFFFFFC);
    chk("bne_rw", {31'd0, bus.reg_write}, 32'd0);
    cyc(1'b1, I_SW, 1'b1);
    chk("sw_imm", bus.imm, 32'd8);
    cyc(1'b1, I_NOP, 1'b1);
    chk("nop_rw", {31'd0, bus.reg_write}, 32'd0);
    cyc(1'b0, 32'd0, 1'b1);

    // Backpressure: two accepted, third held off, head stable.
    cyc(1'b1, I_XOR, 1'b0);
    cyc(1'b1, I_ORI, 1'b0);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc(1'b1, I_SRAI, 1'b0);
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("stall_op", {28'd0, bus.Operation}, 32'h2);
    chk("stall_rd", {27'd0, bus.rd}, 32'd4);
    cyc(1'b1, I_SRAI, 1'b1);
    chk("drain1_op", {28'd0, bus.Operation}, 32'h1);
    cyc(1'b1, I_SRAI, 1'b1);
    chk("drain2_op", {28'd0, bus.Operation}, 32'h6);
    chk("drain2_imm", bus.imm, 32'd3);
    cyc(1'b0, 32'd0, 1'b1);
    chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);

    cyc(1'b1, 32'd0, 1'b1);
    chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
    chk("ill_rw", {31'd0, bus.reg_write}, 32'd0);
    chk("ill_op", {28'd0, bus.Operation}, 32'h0);
    cyc(1'b1, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("ill_count2", {16'd0, bus.illegal_count}, 32'd2);
    cyc(1'b1, I_MUL, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("ill_count3", {16'd0, bus.illegal_count}, 32'd3);
    repeat (65540) cyc(1'b1, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("ill_sat", {16'd0, bus.illegal_count}, 32'h0000FFFF);

    // Reset while FULL drops both entries.
    cyc(1'b1, I_XOR, 1'b0);
    cyc(1'b1, I_ORI, 1'b0);
    chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    cyc(1'b0, 32'd0, 1'b0);
    chk("rstfull_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rstfull_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rstfull_count", {16'd0, bus.illegal_count}, 32'd0);
    chk("rstfull_op", {28'd0, bus.Operation}, 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_decoder.md
ALU_ISSUE_DECODER -- requirements
Module: alu_issue_decoder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, datapath width; OPCODE_LENGTH, default 4, ALU operation-code width.
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have in_valid  input  1  instruction word present.
REQ-005 SHALL have in_instr  input  32  RV32I instruction word.
REQ-006 SHALL have in_ready  output  1  decoder accepts in_instr this cycle.
REQ-007 SHALL have out_valid  output  1  decoded bundle present.
REQ-008 SHALL have out_ready  input  1  downstream ALU stage accepts bundle.
REQ-009 SHALL have Operation  output  OPCODE_LENGTH  ALU operation code.
REQ-010 SHALL have isImmediate  output  1  ALU SrcB is sign-extended 12-bit immediate.
REQ-011 SHALL have imm  output  DATA_WIDTH  immediate value for SrcB.
REQ-012 SHALL have rs1, rs2, rd  output  5 each  register indices.
REQ-013 SHALL have reg_write  output  1  instruction writes rd.
REQ-014 SHALL have illegal  output  1  unsupported opcode/funct combination.
REQ-015 SHALL have illegal_count  output  16  saturating count of illegal bundles delivered.

Function
REQ-016 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-017 Datapath SHALL be a 2-entry skid buffer: latency in->out exactly 1 cycle when empty; full throughput (one per cycle) under continuous out_ready.
REQ-018 in_ready SHALL be registered and equal 1 iff fewer than 2 entries are held after the current cycle's transfers.
REQ-019 Buffer SHALL be strictly FIFO; out_valid/bundle SHALL stay stable while out_valid&&!out_ready.
REQ-020 Buffer states SHALL be EMPTY, ONE, FULL; EMPTY->ONE on accept; ONE->ONE on accept+deliver; ONE->EMPTY on deliver only; ONE->FULL on accept without deliver; FULL->ONE on deliver (no accept possible).
REQ-021 Operation mapping SHALL be: AND/ANDI 0000; OR/ORI 0001; XOR/XORI 0010; ADD/ADDI/LW/SW 0011; SUB 0100; SRL/SRLI 0101; SRA/SRAI 0110; SLL/SLLI 0111; BEQ 1000; BNE 1001; SLT/SLTI/BLT 1010; BGE 1011; JALR 1100; LUI 1101; SLTU/SLTIU/BLTU 1110; BGEU 1111.
REQ-022 I-type and loads SHALL set isImmediate=1, imm=sign-extended instr[31:20]; shift-immediates SHALL set imm={27'b0,instr[24:20]}.
REQ-023 Stores SHALL set isImmediate=1, imm=sign-extended {instr[31:25],instr[11:7]}, reg_write=0.
REQ-024 Branches SHALL set isImmediate=0, reg_write=0, imm=sign-extended B-type offset.
REQ-025 LUI SHALL set isImmediate=0, imm={instr[31:12],12'b0} (full width, not truncated).
REQ-026 SUB vs ADD and SRA vs SRL SHALL be selected by instr[30]; other funct7 values on R-type SHALL be illegal.
REQ-027 Illegal bundles SHALL carry Operation=0000, reg_write=0, illegal=1, and still be delivered in order.
REQ-028 illegal_count SHALL increment on delivery of an illegal bundle, saturating at 16'hFFFF.
REQ-029 rd==0 SHALL force reg_write=0.

Reset
REQ-030 On rst_n low at a clk edge: buffer EMPTY, out_valid=0, in_ready=1, illegal_count=0, all bundle outputs 0, regardless of in-flight entries (dropped).

Structure
REQ-031 RV32I opcode constants, ALU operation-code enum, and decoded-bundle struct SHALL live in shared package alu_pkg.
REQ-032 Pure combinational decode SHALL be sub-module instr_field_decode; alu_issue_decoder holds the skid buffer, handshake and counter.

Verification
REQ-033 Reset, then ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 -> next cycle out_valid=1, Operation=0011, isImmediate=1, imm=0xFFFFFFFB, rd=1, reg_write=1.
REQ-034 SUB x3,x1,x2 (0x402081B3) -> Operation=0100, isImmediate=0, rs1=1, rs2=2; same with instr[30]=0 -> 0011.
REQ-035 LUI x5,0x12345 (0x123452B7) -> Operation=1101, isImmediate=0, imm=0x12345000.
REQ-036 out_ready=0, present 3 back-to-back instructions -> two accepted, in_ready=0 third cycle, bundle held stable; release out_ready -> delivered in order, no loss/duplication.
REQ-037 Stream 0x00000000 (illegal) twice -> illegal=1, reg_write=0, illegal_count=2; preset count to 0xFFFF by 65535 illegals -> stays 0xFFFF.
REQ-038 Assert rst_n=0 while FULL -> next cycle out_valid=0, in_ready=1, illegal_count=0.
